// File: rtl/fetch_hazard_if.sv
// Handshake bundle between the pipeline front end and fetch_hazard_ctrl.
// The pipeline side (master) supplies hazard sources and memory status.
// The controller side (slave) returns enables, flushes and debug state.
interface fetch_hazard_if;
    logic        PCSrc_EX;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rd;
    logic [4:0]  IFID_Rs1;
    logic [4:0]  IFID_Rs2;
    logic        imem_ready;
    logic        imem_req;
    logic        PCWrite;
    logic        Write_IFID;
    logic        Flush_IFID;
    logic        Flush_IDEX;
    logic        fetch_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output PCSrc_EX, IDEX_MemRead, IDEX_Rd, IFID_Rs1, IFID_Rs2, imem_ready,
        input  imem_req, PCWrite, Write_IFID, Flush_IFID, Flush_IDEX,
               fetch_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  PCSrc_EX, IDEX_MemRead, IDEX_Rd, IFID_Rs1, IFID_Rs2, imem_ready,
        output imem_req, PCWrite, Write_IFID, Flush_IFID, Flush_IDEX,
               fetch_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Front-end sequencing controller for the 5-stage pipeline.
// Arbitrates redirects, load-use stalls and instruction-memory waits,
// and keeps saturating stall/flush counters plus a sticky timeout flag.
module fetch_hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_hazard_if.slave  bus
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [8:0] WAIT_LIMIT_W = 9'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [8:0]  wait_inc;
    logic [15:0] stall_q, flush_q;
    logic        timeout_q, timeout_d;
    logic        stall_inc, flush_inc;
    logic        load_use;

    assign load_use = bus.IDEX_MemRead && (bus.IDEX_Rd != 5'd0) &&
                      ((bus.IDEX_Rd == bus.IFID_Rs1) || (bus.IDEX_Rd == bus.IFID_Rs2));

    // Wait count plus one, kept one bit wider so the limit compare never wraps.
    assign wait_inc = {1'b0, wait_q} + 9'd1;

    // Next-state and Mealy output decode; rules are checked in priority order.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d        = state_q;
        wait_d         = wait_q;
        timeout_d      = timeout_q;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        // Fetch is requested in every state once reset is released, and is
        // quiet while rst_n is held low.
        bus.imem_req   = rst_n;
        bus.PCWrite    = 1'b0;
        bus.Write_IFID = 1'b0;
        bus.Flush_IFID = 1'b0;
        bus.Flush_IDEX = 1'b1;

        case (state_q)
            RESET_HOLD: begin
                state_d = RUN;
            end
            default: begin
                if (bus.PCSrc_EX) begin
                    // Redirect: kill the wrong-path slots and abandon any wait.
                    bus.PCWrite    = 1'b1;
                    bus.Write_IFID = 1'b1;
                    bus.Flush_IFID = 1'b1;
                    bus.Flush_IDEX = 1'b1;
                    flush_inc      = 1'b1;
                    wait_d         = 8'd0;
                    state_d        = RUN;
                end else if (load_use) begin
                    // Hold PC and IF/ID, bubble ID/EX; wait progress is frozen.
                    stall_inc      = 1'b1;
                end else if (!bus.imem_ready) begin
                    // Memory not ready: hold PC, feed a NOP into IF/ID.
                    bus.Write_IFID = 1'b1;
                    bus.Flush_IFID = 1'b1;
                    bus.Flush_IDEX = 1'b0;
                    stall_inc      = 1'b1;
                    state_d        = MEM_WAIT;
                    if (wait_q != 8'hFF) begin
                        wait_d = wait_inc[7:0];
                    end
                    if (wait_inc >= WAIT_LIMIT_W) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    bus.PCWrite    = 1'b1;
                    bus.Write_IFID = 1'b1;
                    bus.Flush_IDEX = 1'b0;
                    wait_d         = 8'd0;
                    state_d        = RUN;
                end
            end
        endcase
    end

    // State, wait count, counters and sticky flag, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_HOLD;
            wait_q    <= 8'd0;
            stall_q   <= 16'd0;
            flush_q   <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            if (stall_inc && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush_inc && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;
    assign bus.fetch_timeout = timeout_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: a directed table, hand-written
// multi-cycle sequences, then random traffic against a rule-level model.
module tb_fetch_hazard_ctrl;

    localparam int WL = 4;

    logic clk;
    logic rst_n;

    fetch_hazard_if bus ();

    fetch_hazard_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miscmp;

    // Reference model: plain integers following the priority rules.
    bit m_first;   // the single post-reset hold cycle is in progress
    int m_wait;    // consecutive memory-wait cycles so far
    int m_stall;
    int m_flush;
    bit m_to;

    // Output word order: {PCWrite, Write_IFID, Flush_IFID, Flush_IDEX, imem_req}
    localparam logic [4:0] C_RST    = 5'b00010;
    localparam logic [4:0] C_HOLD   = 5'b00011;
    localparam logic [4:0] C_NORMAL = 5'b11001;
    localparam logic [4:0] C_LU     = 5'b00011;
    localparam logic [4:0] C_WAIT   = 5'b01101;
    localparam logic [4:0] C_REDIR  = 5'b11111;

    typedef struct {
        bit         pcsrc;
        bit         memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit         ready;
        logic [4:0] exp_ctl;
        string      name;
    } vec_t;

    vec_t table_v[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_ctl();
        return {bus.PCWrite, bus.Write_IFID, bus.Flush_IFID, bus.Flush_IDEX, bus.imem_req};
    endfunction

    function automatic bit is_load_use(input bit memread, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return memread && (rd != 0) && ((rd == rs1) || (rd == rs2));
    endfunction

    function automatic logic [4:0] model_ctl(input bit pcsrc, input bit lu, input bit ready);
        if (!rst_n)   return C_RST;
        if (m_first)  return C_HOLD;
        if (pcsrc)    return C_REDIR;
        if (lu)       return C_LU;
        if (!ready)   return C_WAIT;
        return C_NORMAL;
    endfunction

    task automatic model_reset();
        m_first = 1'b1;
        m_wait  = 0;
        m_stall = 0;
        m_flush = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step(input bit pcsrc, input bit lu, input bit ready);
        if (!rst_n) return;
        if (m_first) begin
            m_first = 1'b0;
        end else if (pcsrc) begin
            if (m_flush < 65535) m_flush++;
            m_wait = 0;
        end else if (lu) begin
            if (m_stall < 65535) m_stall++;
        end else if (!ready) begin
            if (m_stall < 65535) m_stall++;
            if (m_wait < 255) m_wait++;
            if (m_wait >= WL) m_to = 1'b1;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic drive(input bit pcsrc, input bit memread, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input bit ready);
        bus.PCSrc_EX     = pcsrc;
        bus.IDEX_MemRead = memread;
        bus.IDEX_Rd      = rd;
        bus.IFID_Rs1     = rs1;
        bus.IFID_Rs2     = rs2;
        bus.imem_ready   = ready;
    endtask

    // Drive now, compare everything 1 ns later, then step the model.
    task automatic apply_now(input bit pcsrc, input bit memread, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input bit ready,
                             input string name);
        bit lu;
        drive(pcsrc, memread, rd, rs1, rs2, ready);
        #1;
        lu = is_load_use(memread, rd, rs1, rs2);
        check({name, ".ctl"},     32'(dut_ctl()),          32'(model_ctl(pcsrc, lu, ready)));
        check({name, ".stall"},   32'(bus.stall_cnt),      32'(m_stall));
        check({name, ".flush"},   32'(bus.flush_cnt),      32'(m_flush));
        check({name, ".timeout"}, 32'(bus.fetch_timeout),  32'(m_to));
        model_step(pcsrc, lu, ready);
    endtask

    task automatic apply(input bit pcsrc, input bit memread, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input bit ready,
                         input string name);
        @(negedge clk);
        apply_now(pcsrc, memread, rd, rs1, rs2, ready, name);
    endtask

    task automatic idle(input string name);
        apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, name);
    endtask

    // Assert reset just after a rising edge, check it took effect at once,
    // then release on a falling edge and check the one-cycle hold.
    task automatic reset_async(input string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({name, ".rst_ctl"},   32'(dut_ctl()),         32'(C_RST));
        check({name, ".rst_stall"}, 32'(bus.stall_cnt),     32'd0);
        check({name, ".rst_flush"}, 32'(bus.flush_cnt),     32'd0);
        check({name, ".rst_to"},    32'(bus.fetch_timeout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_now(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, {name, ".hold"});
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        model_reset();

        // Power-on reset values.
        #2;
        check("por.ctl",   32'(dut_ctl()),         32'(C_RST));
        check("por.stall", 32'(bus.stall_cnt),     32'd0);
        check("por.flush", 32'(bus.flush_cnt),     32'd0);
        check("por.to",    32'(bus.fetch_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_now(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, "por.hold");
        check("por.hold_pcw", 32'(bus.PCWrite), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle("por.run");
            check("por.run_pcw", 32'(bus.PCWrite), 32'd1);
        end
        check("por.stall0", 32'(bus.stall_cnt), 32'd0);

        // Directed decode table, applied back to back in RUN/MEM_WAIT.
        table_v[0]  = '{0, 0, 5'd0, 5'd0, 5'd0, 1, C_NORMAL, "t.normal"};
        table_v[1]  = '{0, 1, 5'd7, 5'd7, 5'd0, 1, C_LU,     "t.lu_rs1"};
        table_v[2]  = '{0, 1, 5'd9, 5'd1, 5'd9, 1, C_LU,     "t.lu_rs2"};
        table_v[3]  = '{0, 1, 5'd0, 5'd0, 5'd0, 1, C_NORMAL, "t.rd_zero"};
        table_v[4]  = '{0, 0, 5'd3, 5'd3, 5'd3, 1, C_NORMAL, "t.not_load"};
        table_v[5]  = '{0, 1, 5'd4, 5'd5, 5'd6, 1, C_NORMAL, "t.no_match"};
        table_v[6]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, C_WAIT,   "t.wait"};
        table_v[7]  = '{0, 1, 5'd2, 5'd2, 5'd0, 0, C_LU,     "t.lu_in_wait"};
        table_v[8]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, C_WAIT,   "t.wait2"};
        table_v[9]  = '{1, 0, 5'd0, 5'd0, 5'd0, 0, C_REDIR,  "t.redir_wait"};
        table_v[10] = '{1, 1, 5'd8, 5'd0, 5'd8, 1, C_REDIR,  "t.redir_lu"};
        table_v[11] = '{0, 0, 5'd0, 5'd0, 5'd0, 1, C_NORMAL, "t.normal2"};
        for (int i = 0; i < 12; i++) begin
            apply(table_v[i].pcsrc, table_v[i].memread, table_v[i].rd,
                  table_v[i].rs1, table_v[i].rs2, table_v[i].ready, table_v[i].name);
            check({table_v[i].name, ".tbl"}, 32'(dut_ctl()), 32'(table_v[i].exp_ctl));
        end

        // Load-use for one cycle, then rd=0 which must not stall.
        reset_async("lu");
        apply(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, "lu.stall");
        idle("lu.after");
        check("lu.stall_cnt", 32'(bus.stall_cnt), 32'd1);
        apply(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, "lu.rd0");
        idle("lu.after_rd0");
        check("lu.rd0_cnt", 32'(bus.stall_cnt), 32'd1);

        // Redirect alone, then redirect together with a load-use.
        reset_async("br");
        apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, "br.redir");
        idle("br.after");
        check("br.flush_cnt", 32'(bus.flush_cnt), 32'd1);
        apply(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, "br.redir_lu");
        idle("br.after2");
        check("br.flush_cnt2", 32'(bus.flush_cnt), 32'd2);
        check("br.stall_cnt",  32'(bus.stall_cnt), 32'd0);

        // Three-cycle memory wait stays below the limit.
        reset_async("mw");
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, "mw.wait");
        idle("mw.after");
        check("mw.stall_cnt", 32'(bus.stall_cnt),     32'd3);
        check("mw.timeout",   32'(bus.fetch_timeout), 32'd0);

        // Four-cycle wait reaches the limit; the flag stays set afterwards.
        reset_async("to");
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, "to.wait");
        check("to.not_yet", 32'(bus.fetch_timeout), 32'd0);
        idle("to.after");
        check("to.set", 32'(bus.fetch_timeout), 32'd1);
        for (int i = 0; i < 3; i++) idle("to.sticky");
        check("to.still_set", 32'(bus.fetch_timeout), 32'd1);

        // Reset in the middle of a wait; the wait count must restart at 0.
        reset_async("rw");
        apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, "rw.wait");
        apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, "rw.wait");
        reset_async("rw.mid");
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, "rw.rewait");
        idle("rw.after");
        check("rw.timeout", 32'(bus.fetch_timeout), 32'd0);
        check("rw.stall",   32'(bus.stall_cnt),     32'd3);

        // Random traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_async("rnd.reset");
            end else begin
                apply($urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) == 0,
                      5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)),
                      $urandom_range(0, 3) != 0,
                      "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
